// File: rtl/irq_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_seq_pkg
// Purpose  : Shared state encoding and cause/PC-select constants.
// Revision : 1.0  initial release
// ============================================================================
package irq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_SERVICE = 3'd3,
    ST_RETURN  = 3'd4
  } state_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_OV  = 5'd12;
  localparam logic [2:0] TRAP_ID = 3'd7;
  localparam logic [1:0] PC_NORM = 2'b00;
  localparam logic [1:0] PC_VEC  = 2'b01;
  localparam logic [1:0] PC_EPC  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Purpose  : 6-bit priority encoder; highest set index wins.
// Revision : 1.0  initial release
// ============================================================================
module irq_prio_enc (
  input  logic [5:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  always_comb begin
    valid = |req;
    idx   = 3'd0;
    // Ascending scan so the last (highest) set bit overrides lower ones.
    for (int i = 0; i < 6; i++) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irq_sequencer
// Purpose  : Interrupt/trap pending capture and exception entry/return FSM.
//            Define IRQ_SYNC_EN to add a two-flop synchronizer on irq_in.
// Revision : 1.0  initial release
// ============================================================================
module irq_sequencer
  import irq_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] irq_in,
  input  logic       alu_trap,
  input  logic       ie,
  input  logic [5:0] im,
  input  logic       exl_in,
  input  logic       eret,
  input  logic       clr_we,
  input  logic [5:0] clr_mask,
  output logic [5:0] cp0_interrupt,
  output logic       stall,
  output logic       flush,
  output logic       take_exc,
  output logic       epc_we,
  output logic [1:0] pc_sel,
  output logic [4:0] exc_code,
  output logic [2:0] irq_id,
  output logic       busy,
  output logic       trap_lost
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_irq_prev;
  logic [5:0] r_pending;
  logic [4:0] r_exc_code;
  logic [2:0] r_irq_id;
  logic       r_trap_lost;
  logic [5:0] w_irq_src;
  logic [5:0] w_rise;
  logic [5:0] w_clr;
  logic [5:0] w_req;
  logic       w_req_valid;
  logic [2:0] w_win;
  logic       w_take;

`ifdef IRQ_SYNC_EN
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_src = r_sync2;
`else
  assign w_irq_src = irq_in;
`endif

  assign w_rise = w_irq_src & ~r_irq_prev;
  assign w_clr  = clr_we ? clr_mask : 6'd0;
  assign w_req  = r_pending & im;

  irq_prio_enc u_prio_enc (
    .req   (w_req),
    .valid (w_req_valid),
    .idx   (w_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_irq_prev  <= '0;
      r_pending   <= '0;
      r_exc_code  <= '0;
      r_irq_id    <= '0;
      r_trap_lost <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= w_irq_src;
      // OR-ing the rise in after the clear makes a same-cycle set win.
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      if (w_take) begin
        r_exc_code <= alu_trap ? EXC_OV  : EXC_INT;
        r_irq_id   <= alu_trap ? TRAP_ID : w_win;
      end
      if (r_state != ST_IDLE && alu_trap) r_trap_lost <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    take_exc    = 1'b0;
    epc_we      = 1'b0;
    pc_sel      = PC_NORM;
    case (r_state)
      ST_IDLE: begin
        if (ie && !exl_in && (alu_trap || w_req_valid)) begin
          w_take      = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        stall       = 1'b1;
        flush       = 1'b1;
        w_state_nxt = ST_VECTOR;
      end
      ST_VECTOR: begin
        stall       = 1'b1;
        take_exc    = 1'b1;
        epc_we      = 1'b1;
        pc_sel      = PC_VEC;
        w_state_nxt = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eret) w_state_nxt = ST_RETURN;
      end
      ST_RETURN: begin
        pc_sel      = PC_EPC;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Strobes are silenced while reset is held, even before the state clears.
    if (rst) begin
      w_take   = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      take_exc = 1'b0;
      epc_we   = 1'b0;
      pc_sel   = PC_NORM;
    end
  end

  assign cp0_interrupt = r_pending;
  assign exc_code      = r_exc_code;
  assign irq_id        = r_irq_id;
  assign trap_lost     = r_trap_lost;
  assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_sequencer
// Purpose  : Self-checking bench with a vector scoreboard for irq_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_sequencer;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] irq_in;
  logic       alu_trap;
  logic       ie;
  logic [5:0] im;
  logic       exl_in;
  logic       eret;
  logic       clr_we;
  logic [5:0] clr_mask;
  logic [5:0] cp0_interrupt;
  logic       stall, flush, take_exc, epc_we;
  logic [1:0] pc_sel;
  logic [4:0] exc_code;
  logic [2:0] irq_id;
  logic       busy, trap_lost;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {exc_code, irq_id} for each vector the DUT should take.
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  irq_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .alu_trap      (alu_trap),
    .ie            (ie),
    .im            (im),
    .exl_in        (exl_in),
    .eret          (eret),
    .clr_we        (clr_we),
    .clr_mask      (clr_mask),
    .cp0_interrupt (cp0_interrupt),
    .stall         (stall),
    .flush         (flush),
    .take_exc      (take_exc),
    .epc_we        (epc_we),
    .pc_sel        (pc_sel),
    .exc_code      (exc_code),
    .irq_id        (irq_id),
    .busy          (busy),
    .trap_lost     (trap_lost)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard consumer: every vector cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && take_exc) begin
      if (sb_q.size() == 0) begin
        chk("vec_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        chk("vec_exc_code", 32'(exc_code), 32'(e[7:3]));
        chk("vec_irq_id",   32'(irq_id),   32'(e[2:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first;
    rst = 1'b1; irq_in = 6'h3F; alu_trap = 1'b0; ie = 1'b0; im = 6'h00;
    exl_in = 1'b0; eret = 1'b0; clr_we = 1'b0; clr_mask = 6'h00;
    tickn(2);
    chk("rst_pending", 32'(cp0_interrupt), 32'h00);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_pc_sel",  32'(pc_sel),        32'd0);
    chk("rst_lost",    32'(trap_lost),     32'd0);
    irq_in = 6'h00;
    tickn(1 + SYNC_LAT);
    rst = 1'b0;
    tickn(1);

    // Interrupt on lines 5 and 0: line 5 wins, full entry/return sequence.
    ie = 1'b1; im = 6'h3F;
    irq_in = 6'h21;
    sb_q.push_back({5'd0, 3'd5});
    tickn(1);
    irq_in = 6'h00;
    tickn(SYNC_LAT);
    chk("irq_pending", 32'(cp0_interrupt), 32'h21);
    chk("irq_idle",    32'(busy),          32'd0);
    tickn(1);
    chk("flush_state", 32'({busy, stall, flush, take_exc}), 32'b1110);
    tickn(1);
    chk("vector_strb", 32'({stall, take_exc, epc_we, pc_sel}), 32'b11101);
    tickn(1);
    chk("service_st",  32'({busy, stall, pc_sel}), 32'b1000);
    clr_we = 1'b1; clr_mask = 6'h3F;
    tickn(1);
    clr_we = 1'b0;
    chk("svc_clear",   32'(cp0_interrupt), 32'h00);
    chk("svc_hold",    32'(busy),          32'd1);
    eret = 1'b1;
    tickn(1);
    eret = 1'b0;
    chk("return_pc",   32'({busy, pc_sel}), 32'b110);
    tickn(1);
    chk("back_idle",   32'({busy, pc_sel}), 32'b000);

    // eret in IDLE is ignored.
    eret = 1'b1;
    tickn(1);
    eret = 1'b0;
    chk("eret_idle",   32'(busy), 32'd0);

    // Trap and pending line 0 in the same cycle: trap wins, pending untouched.
    ie = 1'b0;
    irq_in = 6'h01;
    tickn(1 + SYNC_LAT);
    chk("p0_pending",  32'(cp0_interrupt), 32'h01);
    ie = 1'b1; alu_trap = 1'b1;
    sb_q.push_back({5'd12, 3'd7});
    tickn(1);
    alu_trap = 1'b0;
    chk("trap_flush",  32'(flush), 32'd1);
    chk("trap_keep_p", 32'(cp0_interrupt), 32'h01);
    tickn(2);
    chk("trap_code",   32'({exc_code, irq_id}), 32'({5'd12, 3'd7}));
    chk("trap_lost0",  32'(trap_lost), 32'd0);
    alu_trap = 1'b1;
    tickn(1);
    alu_trap = 1'b0;
    chk("trap_lost1",  32'(trap_lost), 32'd1);
    clr_we = 1'b1; clr_mask = 6'h01;
    irq_in = 6'h00;
    tickn(1 + SYNC_LAT);
    clr_we = 1'b0;
    eret = 1'b1;
    tickn(1);
    eret = 1'b0;
    tickn(3);
    chk("lost_sticky", 32'({trap_lost, busy}), 32'b10);

    // Same-cycle set and clear: set wins; then a lone clear of bit 5.
    ie = 1'b0;
    clr_we = 1'b1; clr_mask = 6'h01;
    irq_in = 6'h01;
    tickn(1 + SYNC_LAT);
    clr_we = 1'b0;
    chk("set_beats_clr", 32'(cp0_interrupt), 32'h01);
    irq_in = 6'h21;
    tickn(1 + SYNC_LAT);
    chk("p5_set",      32'(cp0_interrupt), 32'h21);
    clr_we = 1'b1; clr_mask = 6'h20;
    tickn(1);
    clr_we = 1'b0;
    chk("clr_bit5",    32'(cp0_interrupt), 32'h01);
    clr_we = 1'b1; clr_mask = 6'h3F; irq_in = 6'h00;
    tickn(1);
    clr_we = 1'b0;

    // Masking and exl gating: lines 1 and 3 pending, only lines 0-2 enabled.
    irq_in = 6'h0A;
    tickn(1 + SYNC_LAT);
    irq_in = 6'h00;
    chk("p13_pending", 32'(cp0_interrupt), 32'h0A);
    im = 6'h07; ie = 1'b1; exl_in = 1'b1;
    tickn(2);
    chk("exl_blocks",  32'(busy), 32'd0);
    exl_in = 1'b0;
    sb_q.push_back({5'd0, 3'd1});
    tickn(3);
    chk("mask_id",     32'({exc_code, irq_id}), 32'({5'd0, 3'd1}));
    tickn(1);
    chk("svc2",        32'(busy), 32'd1);

    // Reset from SERVICE.
    rst = 1'b1;
    #1;
    chk("rst_strobes", 32'({stall, flush, take_exc, epc_we, pc_sel}), 32'd0);
    tickn(1);
    rst = 1'b0;
    chk("rst_svc_idle", 32'({busy, cp0_interrupt}), 32'd0);
    chk("rst_svc_lost", 32'(trap_lost), 32'd0);

    // Pending latency from a rising irq_in[3].
    ie = 1'b0;
    irq_in = 6'h08;
    first = 0;
    for (int k = 1; k <= 5; k++) begin
      tickn(1);
      if (first == 0 && cp0_interrupt[3]) first = k;
    end
    chk("p3_latency",  32'(first), 32'(1 + SYNC_LAT));

    tickn(2);
    chk("sb_empty",    32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
